seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//  Reader end of the 7-segment display interface: samples a multiplexed (scanned) segment bus
//  {segment lines + one-hot digit enables} and reconstructs the hex value shown on each digit.
//  Sits on the board-facing side as a self-check/loopback monitor for hex_7seg_decoder-driven
//  displays. Outputs registered per-digit nibbles, valid/error flags and a frame-complete pulse.
// PARAMETERS
//  N_DIGITS      4  number of scanned digits (1..8)
//  COMMON_ANODE  0  0: segment on = 1; 1: segment on = 0 (input inverted before decode)
//  DIG_ACT_LOW   0  0: i_dig_en active-high; 1: active-low (inverted before use)
//  STABLE_CYCLES 4  clocks {seg,dig} must be unchanged before a capture (>=1)
// PORTS
//  i_clk          in   1           system clock
//  i_rst          in   1           asynchronous, active-high reset
//  i_seg          in   7           segment lines, bit0=a .. bit6=g (same order as o_HEX)
//  i_dig_en       in   N_DIGITS    digit select, expected one-hot (or all-off = blanking)
//  o_value        out  4*N_DIGITS  decoded nibbles, digit d at [4d+3:4d]
//  o_digit_valid  out  N_DIGITS    digit d holds a valid capture
//  o_err          out  N_DIGITS    last capture on digit d was a non-hex pattern
//  o_frame_done   out  1           1-cycle pulse: every digit captured since last pulse
//  o_onehot_err   out  1           1-cycle pulse: stable multi-hot digit select seen
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; sync regs, stability counter,
//    captured mask, slot-captured flag cleared. Reset mid-frame discards partial frame.
//  - Input path: 2-FF synchronizer on i_seg and i_dig_en, then polarity normalisation.
//  - Stability: counter clears when synced {seg,dig} differs from previous cycle, else
//    increments, saturating at STABLE_CYCLES. Capture event fires once, on the cycle the
//    counter reaches STABLE_CYCLES; no further capture until {seg,dig} changes.
//  - Latency: pins stable -> o_* updated on the (2 + STABLE_CYCLES + 1)th rising edge.
//  - Capture with dig all-zero: no action (blanking). Multi-hot: o_onehot_err pulses,
//    no value/flag/mask change.
//  - Capture with one-hot digit d: decode pattern (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D
//    6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//    Match: nibble d <= value, o_digit_valid[d]<=1, o_err[d]<=0.
//    No match: nibble d held, o_digit_valid[d]<=0, o_err[d]<=1.
//    Either case sets captured_mask[d].
//  - Frame: when captured_mask (incl. this cycle's bit) is all-ones, o_frame_done pulses in
//    the same cycle the final digit's outputs update; mask clears that cycle.
//  - Recapture of an already-captured digit before frame end: outputs update, mask unchanged.
//  - Other digits' outputs never change on a capture of digit d.
// STRUCTURE
//  - Package seg7_pkg: SEG_* pattern constants (shared with hex_7seg_decoder so tables
//    cannot diverge), seg7_t typedef (7-bit), function seg_to_hex(seg7_t)->{ok,nibble}.
//  - Sub-module seg7_pattern_decode: combinational 7-bit -> {valid, 4-bit}, uses package.
//  - Top: synchronizer, stability counter, one-hot check, per-digit regs, frame mask.
// TESTING (defaults unless stated; patterns given active-high)
//  1 Assert i_rst mid-run -> all o_* = 0 immediately; no o_frame_done after release until
//    all 4 digits recaptured.
//  2 Scan d0..d3 = 06,5B,4F,66, each held 8 clk -> o_value=16'h4321, o_digit_valid=4'hF,
//    o_err=0, exactly one o_frame_done pulse, 7 edges after d3 appears at pins.
//  3 d1 pattern 3F held 3 clk then 06 held 8 clk -> nibble1 = 1 only, never 0.
//  4 d2 pattern 00 held 8 clk after valid 7F -> o_err[2]=1, o_digit_valid[2]=0,
//    nibble2 stays 8.
//  5 i_dig_en=4'b0011 held 8 clk -> one o_onehot_err pulse; o_value, flags, mask unchanged.
//  6 COMMON_ANODE=1, DIG_ACT_LOW=1: i_seg=~7'h71, i_dig_en=~4'b0001 -> nibble0 = F, valid[0]=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern table and decode helper (segment order gfedcba, bit0=a).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] nib;
  } hex_dec_t;

  localparam seg7_t SEG_0 = 7'h3F;
  localparam seg7_t SEG_1 = 7'h06;
  localparam seg7_t SEG_2 = 7'h5B;
  localparam seg7_t SEG_3 = 7'h4F;
  localparam seg7_t SEG_4 = 7'h66;
  localparam seg7_t SEG_5 = 7'h6D;
  localparam seg7_t SEG_6 = 7'h7D;
  localparam seg7_t SEG_7 = 7'h07;
  localparam seg7_t SEG_8 = 7'h7F;
  localparam seg7_t SEG_9 = 7'h6F;
  localparam seg7_t SEG_A = 7'h77;
  localparam seg7_t SEG_B = 7'h7C;
  localparam seg7_t SEG_C = 7'h39;
  localparam seg7_t SEG_D = 7'h5E;
  localparam seg7_t SEG_E = 7'h79;
  localparam seg7_t SEG_F = 7'h71;

  // Reverse lookup: any pattern outside the 16 glyphs reports ok=0.
  function automatic hex_dec_t seg_to_hex(seg7_t s);
    hex_dec_t r;
    r.ok  = 1'b1;
    r.nib = 4'h0;
    case (s)
      SEG_0: r.nib = 4'h0;
      SEG_1: r.nib = 4'h1;
      SEG_2: r.nib = 4'h2;
      SEG_3: r.nib = 4'h3;
      SEG_4: r.nib = 4'h4;
      SEG_5: r.nib = 4'h5;
      SEG_6: r.nib = 4'h6;
      SEG_7: r.nib = 4'h7;
      SEG_8: r.nib = 4'h8;
      SEG_9: r.nib = 4'h9;
      SEG_A: r.nib = 4'hA;
      SEG_B: r.nib = 4'hB;
      SEG_C: r.nib = 4'hC;
      SEG_D: r.nib = 4'hD;
      SEG_E: r.nib = 4'hE;
      SEG_F: r.nib = 4'hF;
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern -> {valid, nibble}.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       ok,
  output logic [3:0] nib
);

  hex_dec_t dec;

  // Table lives in the package so encoder and reader cannot drift apart.
  always_comb begin
    dec = seg_to_hex(seg);
    ok  = dec.ok;
    nib = dec.nib;
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Scanned 7-segment bus monitor: syncs pins, waits for a stable pattern,
// decodes it into the selected digit's slot and reports frame completion.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int COMMON_ANODE  = 0,
  parameter int DIG_ACT_LOW   = 0,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_seg,
  input  logic [N_DIGITS-1:0]   i_dig_en,
  output logic [4*N_DIGITS-1:0] o_value,
  output logic [N_DIGITS-1:0]   o_digit_valid,
  output logic [N_DIGITS-1:0]   o_err,
  output logic                  o_frame_done,
  output logic                  o_onehot_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic                rst_meta, rst_q;
  logic [6:0]          seg_s1, seg_s2, seg_n, prev_seg;
  logic [N_DIGITS-1:0] dig_s1, dig_s2, dig_n, prev_dig;
  logic [N_DIGITS-1:0] mask, mask_nx;
  logic [CW-1:0]       cnt;
  logic                changed, capture, blank, multi;
  logic                dec_ok;
  logic [3:0]          dec_nib;

  // Reset asserts immediately, releases two clocks after i_rst drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) {rst_q, rst_meta} <= 2'b11;
    else       {rst_q, rst_meta} <= {rst_meta, 1'b0};
  end

  // Two-flop synchronizer on the whole pin bus.
  always_ff @(posedge i_clk or posedge rst_q) begin
    if (rst_q) begin
      seg_s1 <= '0; seg_s2 <= '0;
      dig_s1 <= '0; dig_s2 <= '0;
    end else begin
      seg_s1 <= i_seg;  seg_s2 <= seg_s1;
      dig_s1 <= i_dig_en; dig_s2 <= dig_s1;
    end
  end

  assign seg_n = (COMMON_ANODE != 0) ? ~seg_s2 : seg_s2;
  assign dig_n = (DIG_ACT_LOW  != 0) ? ~dig_s2 : dig_s2;

  assign changed = ({seg_n, dig_n} != {prev_seg, prev_dig});
  // Fires exactly once per stable pattern: the cycle the count would reach the limit.
  assign capture = !changed && (cnt == CW'(STABLE_CYCLES - 1));
  assign blank   = (dig_n == '0);
  assign multi   = ((dig_n & (dig_n - N_DIGITS'(1))) != '0);
  assign mask_nx = mask | dig_n;

  // Stability counter, cleared on any change, saturating at the limit.
  always_ff @(posedge i_clk or posedge rst_q) begin
    if (rst_q) begin
      prev_seg <= '0;
      prev_dig <= '0;
      cnt      <= '0;
    end else begin
      prev_seg <= seg_n;
      prev_dig <= dig_n;
      if (changed)                        cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + CW'(1);
    end
  end

  seg7_pattern_decode u_dec (
    .seg (seg_n),
    .ok  (dec_ok),
    .nib (dec_nib)
  );

  // Per-digit result registers, frame mask and status pulses.
  always_ff @(posedge i_clk or posedge rst_q) begin
    if (rst_q) begin
      o_value       <= '0;
      o_digit_valid <= '0;
      o_err         <= '0;
      mask          <= '0;
      o_frame_done  <= 1'b0;
      o_onehot_err  <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_onehot_err <= 1'b0;
      if (capture && multi) begin
        o_onehot_err <= 1'b1;
      end else if (capture && !blank) begin
        for (int d = 0; d < N_DIGITS; d++) begin
          if (dig_n[d]) begin
            if (dec_ok) o_value[4*d +: 4] <= dec_nib;
            o_digit_valid[d] <= dec_ok;
            o_err[d]         <= !dec_ok;
          end
        end
        if (mask_nx == '1) begin
          o_frame_done <= 1'b1;
          mask         <= '0;
        end else begin
          mask <= mask_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed + random bench for seg7_scan_capture with a pattern-level reference model.
module tb_seg7_scan_capture;

  localparam int N = 4;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg, seg2;
  logic [N-1:0]  dig, dig2;
  logic [4*N-1:0] o_value, o2_value;
  logic [N-1:0]  o_digit_valid, o_err, o2_digit_valid, o2_err;
  logic          o_frame_done, o_onehot_err, o2_frame_done, o2_onehot_err;

  always #5 clk = ~clk;

  seg7_scan_capture dut (
    .i_clk(clk), .i_rst(rst), .i_seg(seg), .i_dig_en(dig),
    .o_value(o_value), .o_digit_valid(o_digit_valid), .o_err(o_err),
    .o_frame_done(o_frame_done), .o_onehot_err(o_onehot_err)
  );

  seg7_scan_capture #(.COMMON_ANODE(1), .DIG_ACT_LOW(1)) dut_inv (
    .i_clk(clk), .i_rst(rst), .i_seg(seg2), .i_dig_en(dig2),
    .o_value(o2_value), .o_digit_valid(o2_digit_valid), .o_err(o2_err),
    .o_frame_done(o2_frame_done), .o_onehot_err(o2_onehot_err)
  );

  int n_chk = 0, n_err = 0;
  int fd_cnt = 0, ohe_cnt = 0;
  bit watch1 = 0, bad1 = 0;

  always @(negedge clk) begin
    if (o_frame_done) fd_cnt++;
    if (o_onehot_err) ohe_cnt++;
    if (watch1 && o_value[7:4] == 4'h0) bad1 = 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: a pattern held at the pins for S+1 clocks or longer
  // is taken exactly once.
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0]   m_val [N];
  logic [N-1:0] m_vld, m_err, m_mask;
  int           m_fd = 0, m_ohe = 0;
  logic [6:0]   l_seg;
  logic [N-1:0] l_dig;
  int           run;
  bit           capd;

  function automatic int lookup(logic [6:0] p);
    for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
    return -1;
  endfunction

  task automatic model_take(logic [6:0] p, logic [N-1:0] d);
    int r, ones;
    ones = 0;
    for (int i = 0; i < N; i++) ones += d[i];
    if (ones == 0) return;
    if (ones > 1) begin m_ohe++; return; end
    r = lookup(p);
    for (int i = 0; i < N; i++) if (d[i]) begin
      if (r >= 0) begin m_val[i] = 4'(r); m_vld[i] = 1; m_err[i] = 0; end
      else begin m_vld[i] = 0; m_err[i] = 1; end
    end
    m_mask |= d;
    if (m_mask == '1) begin m_fd++; m_mask = '0; end
  endtask

  task automatic drive(logic [6:0] p, logic [N-1:0] d, int hold, output int fd_at);
    seg = p; dig = d;
    if (p == l_seg && d == l_dig) run += hold;
    else begin run = hold; capd = 0; l_seg = p; l_dig = d; end
    if (!capd && run >= S + 1) begin capd = 1; model_take(p, d); end
    fd_at = -1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (o_frame_done && fd_at < 0) fd_at = k;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(string tag);
    int x;
    logic [4*N-1:0] v;
    drive(l_seg, l_dig, S + 4, x);
    for (int i = 0; i < N; i++) v[4*i +: 4] = m_val[i];
    chk({tag, ".value"}, 32'(o_value), 32'(v));
    chk({tag, ".valid"}, 32'(o_digit_valid), 32'(m_vld));
    chk({tag, ".err"},   32'(o_err), 32'(m_err));
    chk({tag, ".frames"}, 32'(fd_cnt), 32'(m_fd));
    chk({tag, ".onehot"}, 32'(ohe_cnt), 32'(m_ohe));
  endtask

  task automatic do_reset(string tag);
    int x;
    rst = 1; seg = '0; dig = '0; seg2 = '0; dig2 = '1;
    #1;
    chk({tag, ".value0"}, 32'(o_value), 32'h0);
    chk({tag, ".flags0"}, {o_digit_valid, o_err, o_frame_done, o_onehot_err}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < N; i++) m_val[i] = '0;
    m_vld = '0; m_err = '0; m_mask = '0;
    l_seg = '0; l_dig = '0; run = 100; capd = 1;
    drive(7'h00, 4'b0000, 4, x);
  endtask

  initial begin
    int fd_at, x, r, ones;
    logic [6:0] p;
    logic [N-1:0] d;

    do_reset("rst_init");

    // Straight scan 1,2,3,4 and frame latency from last digit.
    drive(7'h06, 4'b0001, 8, x);
    drive(7'h5B, 4'b0010, 8, x);
    drive(7'h4F, 4'b0100, 8, x);
    drive(7'h66, 4'b1000, 8, fd_at);
    chk("frame_latency", 32'(fd_at), 32'd7);
    chk("scan_value", 32'(o_value), 32'h4321);
    chk_model("scan");
    chk("scan_frames", 32'(fd_cnt), 32'd1);

    // Short-lived 0 glyph on digit 1 must not be taken.
    watch1 = 1;
    drive(7'h3F, 4'b0010, 3, x);
    drive(7'h06, 4'b0010, 8, x);
    watch1 = 0;
    chk("glitch_nib1", 32'(o_value[7:4]), 32'h1);
    chk("glitch_never0", 32'(bad1), 32'h0);

    // Bad pattern after a good 8 on digit 2.
    drive(7'h7F, 4'b0100, 8, x);
    drive(7'h00, 4'b0100, 8, x);
    chk_model("badpat");
    chk("badpat_err2", 32'(o_err[2]), 32'h1);
    chk("badpat_vld2", 32'(o_digit_valid[2]), 32'h0);
    chk("badpat_nib2", 32'(o_value[11:8]), 32'h8);

    // Multi-hot select.
    drive(7'h3F, 4'b0011, 8, x);
    chk_model("multihot");
    chk("multihot_pulses", 32'(ohe_cnt), 32'd1);

    // Remaining digits close the frame begun above.
    drive(7'h6D, 4'b0001, 8, x);
    drive(7'h7D, 4'b1000, 8, x);
    chk_model("close");

    // Reset mid-frame drops the partial mask.
    drive(7'h77, 4'b0001, 8, x);
    drive(7'h7C, 4'b0010, 8, x);
    drive(7'h39, 4'b0100, 8, x);
    do_reset("rst_mid");
    drive(7'h5E, 4'b1000, 8, x);
    chk_model("after_rst_d3");
    drive(7'h79, 4'b0001, 8, x);
    drive(7'h71, 4'b0010, 8, x);
    drive(7'h07, 4'b0100, 8, x);
    chk_model("after_rst_full");

    // Random scan traffic.
    for (int s = 0; s < 80; s++) begin
      r = $urandom_range(0, 9);
      if (r == 0) d = '0;
      else if (r == 1) begin
        do begin
          d = N'($urandom);
          ones = 0;
          for (int i = 0; i < N; i++) ones += d[i];
        end while (ones < 2);
      end else d = N'(1) << $urandom_range(0, N - 1);
      if ($urandom_range(0, 4) != 0) p = tbl[$urandom_range(0, 15)];
      else p = 7'($urandom);
      drive(p, d, $urandom_range(1, 9), x);
      if (s % 10 == 9) chk_model("rand");
    end

    // Inverted-polarity instance.
    seg2 = ~7'h71; dig2 = ~4'b0001;
    repeat (10) @(negedge clk);
    chk("inv_nib0", 32'(o2_value[3:0]), 32'hF);
    chk("inv_vld0", 32'(o2_digit_valid[0]), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
